// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size codes and FSM state encoding for dmem_target.
// No ports; imported with import dmem_pkg::*.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_target_lane.sv
// dmem_lane: byte-lane steering for stores, extraction/extension for loads.
// In: addr_lo, size, we, wdata, rword. Out: wmask, wdata_sh, rdata, err.
// DMEM_TARGET_ERR_EN builds the alignment/size checks; otherwise err is 0.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata,
    output logic        err
);

    logic        is_b;
    logic        is_h;
    logic        sext;
    logic [1:0]  lane;
    logic [4:0]  sh;
    logic [3:0]  base;
    logic [31:0] wsel;
    logic [31:0] rsh;

    // Unlisted sizes fall through to word access.
    always_comb begin
        is_b = 1'b0;
        is_h = 1'b0;
        sext = 1'b0;
        unique case (size)
            SZ_B:  begin is_b = 1'b1; sext = 1'b1; end
            SZ_H:  begin is_h = 1'b1; sext = 1'b1; end
            SZ_BU: is_b = 1'b1;
            SZ_HU: is_h = 1'b1;
            default: ;
        endcase
    end

`ifdef DMEM_TARGET_ERR_EN
    logic bad_size;
    logic bad_algn;
    logic bad_st;

    assign bad_size = (size == 3'b011) || (size == 3'b110)
                   || (size == 3'b111);
    assign bad_algn = (is_h && addr_lo[0])
                   || ((size == SZ_W) && (addr_lo != 2'b00));
    assign bad_st   = we && ((size == SZ_BU) || (size == SZ_HU));
    assign err      = bad_size || bad_algn || bad_st;
`else
    assign err = 1'b0;
`endif

    // Misaligned H/W are forced onto their natural lane.
    always_comb begin
        lane = 2'b00;
        unique case (1'b1)
            is_b:    lane = addr_lo;
            is_h:    lane = {addr_lo[1], 1'b0};
            default: lane = 2'b00;
        endcase
    end

    assign sh = {lane, 3'b000};

    always_comb begin
        base = 4'b1111;
        wsel = wdata;
        unique case (1'b1)
            is_b: begin
                base = 4'b0001;
                wsel = {24'b0, wdata[7:0]};
            end
            is_h: begin
                base = 4'b0011;
                wsel = {16'b0, wdata[15:0]};
            end
            default: ;
        endcase
    end

    assign wmask    = (we && !err) ? (base << lane) : 4'b0000;
    assign wdata_sh = wsel << sh;
    assign rsh      = rword >> sh;

    always_comb begin
        rdata = rsh;
        unique case (1'b1)
            is_b:    rdata = {{24{sext & rsh[7]}}, rsh[7:0]};
            is_h:    rdata = {{16{sext & rsh[15]}}, rsh[15:0]};
            default: rdata = rsh;
        endcase
        if (err) rdata = '0;
    end

endmodule

// File: rtl/dmem_target.sv
// dmem_target: data-memory responder, valid/ready req/rsp, one outstanding.
// Ports: clk, reset (async low), req_*, rsp_*. Macro: DMEM_TARGET_ERR_EN.
module dmem_target
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int DEPTH = 1 << (ADDR_W - 2);
    localparam logic [2:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic [31:0]       wdata_q;

    logic              accept;
    logic              exec;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [2:0]        a_size;
    logic [31:0]       a_wdata;
    logic [ADDR_W-3:0] idx;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       rword;
    logic [3:0]        wmask;
    logic [31:0]       wdata_sh;
    logic [31:0]       ld_data;
    logic              lane_err;

    assign accept = req_valid && req_ready;

    // With no wait states the access runs on the accept edge itself.
    assign exec = (WAIT_CYCLES == 0) ? accept
                : ((state == ST_WAIT) && (cnt == 3'd0));

    // Live inputs in IDLE (zero-wait path), latched copy otherwise.
    assign a_we    = (state == ST_IDLE) ? req_we    : we_q;
    assign a_addr  = (state == ST_IDLE) ? req_addr  : addr_q;
    assign a_size  = (state == ST_IDLE) ? req_size  : size_q;
    assign a_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;

    assign idx   = a_addr[ADDR_W-1:2];
    assign rword = mem[idx];

    dmem_lane u_lane (
        .addr_lo  (a_addr[1:0]),
        .size     (a_size),
        .we       (a_we),
        .wdata    (a_wdata),
        .rword    (rword),
        .wmask    (wmask),
        .wdata_sh (wdata_sh),
        .rdata    (ld_data),
        .err      (lane_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept)
                state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt == 3'd0) state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready)   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE) && reset;
        rsp_valid = (state == ST_RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 3'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            size_q    <= 3'd0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                cnt     <= CNT_INIT;
                we_q    <= req_we;
                addr_q  <= req_addr;
                size_q  <= req_size;
                wdata_q <= req_wdata;
            end else if ((state == ST_WAIT) && (cnt != 3'd0)) begin
                cnt <= cnt - 3'd1;
            end
            if (exec)
                rsp_rdata <= (a_we || lane_err) ? '0 : ld_data;
        end
    end

`ifdef DMEM_TARGET_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    err_q <= 1'b0;
        else if (exec) err_q <= lane_err;
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Array is never reset; wmask is already gated by store and error.
    always_ff @(posedge clk) begin
        if (exec) begin
            for (int i = 0; i < 4; i++)
                if (wmask[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_target.sv
// tb_dmem_target: directed bench, unit 0 with WAIT_CYCLES=3, unit 1 with 0.
// Checks data, errors, latency, backpressure, reset abort, address range.
module tb_dmem_target;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [13:0] req_addr  [2];
    logic [2:0]  req_size  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_target #(.ADDR_W(14), .WAIT_CYCLES(3)) dut (
        .clk       (clk),
        .reset     (rst_n[0]),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_we    (req_we[0]),
        .req_addr  (req_addr[0]),
        .req_size  (req_size[0]),
        .req_wdata (req_wdata[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0])
    );

    dmem_target #(.ADDR_W(14), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .reset     (rst_n[1]),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_we    (req_we[1]),
        .req_addr  (req_addr[1]),
        .req_size  (req_size[1]),
        .req_wdata (req_wdata[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction; hold = cycles to stall rsp_ready after rsp_valid.
    task automatic op(input int u, input string tag, input logic we,
                      input logic [13:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic exp_er, input int hold);
        int n;
        int lat;
        n = 0;
        @(negedge clk);
        req_we[u]    = we;
        req_addr[u]  = a;
        req_size[u]  = sz;
        req_wdata[u] = wd;
        req_valid[u] = 1'b1;
        while (!req_ready[u] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reqrdy"}, 32'(req_ready[u]), 32'd1);
        @(posedge clk); #1;
        req_valid[u] = 1'b0;
        lat = 1;
        while (!rsp_valid[u] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), (u == 0) ? 32'd4 : 32'd1);
        chk({tag, "_rd"}, rsp_rdata[u], exp_rd);
        chk({tag, "_err"}, 32'(rsp_err[u]), 32'(exp_er));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hvalid"}, 32'(rsp_valid[u]), 32'd1);
            chk({tag, "_hrd"}, rsp_rdata[u], exp_rd);
            chk({tag, "_hready"}, 32'(req_ready[u]), 32'd0);
        end
        rsp_ready[u] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[u] = 1'b0;
        chk({tag, "_postrdy"}, 32'(req_ready[u]), 32'd1);
        chk({tag, "_postvld"}, 32'(rsp_valid[u]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_n[u]     = 1'b0;
            req_valid[u] = 1'b0;
            req_we[u]    = 1'b0;
            req_addr[u]  = '0;
            req_size[u]  = SZ_W;
            req_wdata[u] = '0;
            rsp_ready[u] = 1'b0;
        end
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_reqrdy", 32'(req_ready[u]), 32'd0);
            chk("rst_valid", 32'(rsp_valid[u]), 32'd0);
            chk("rst_rdata", rsp_rdata[u], 32'd0);
            chk("rst_err", 32'(rsp_err[u]), 32'd0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        #1;
        chk("rel_reqrdy0", 32'(req_ready[0]), 32'd1);
        chk("rel_reqrdy1", 32'(req_ready[1]), 32'd1);

        op(0, "stw10", 1, 14'h10, SZ_W, 32'hDEADBEEF, 0, 0, 0);
        op(0, "ldw10", 0, 14'h10, SZ_W, 0, 32'hDEADBEEF, 0, 0);
        op(0, "stb13", 1, 14'h13, SZ_B, 32'h12345680, 0, 0, 0);
        op(0, "ldb13", 0, 14'h13, SZ_B, 0, 32'hFFFFFF80, 0, 0);
        op(0, "ldbu13", 0, 14'h13, SZ_BU, 0, 32'h00000080, 0, 0);
        op(0, "ldw10b", 0, 14'h10, SZ_W, 0, 32'h80ADBEEF, 0, 0);
        op(0, "ldh12", 0, 14'h12, SZ_H, 0, 32'hFFFF80AD, 0, 0);
        op(0, "ldhu12", 0, 14'h12, SZ_HU, 0, 32'h000080AD, 0, 0);
        op(0, "ldb10", 0, 14'h10, SZ_B, 0, 32'hFFFFFFEF, 0, 0);
        op(0, "ldbu11", 0, 14'h11, SZ_BU, 0, 32'h000000BE, 0, 0);
        op(0, "sth10", 1, 14'h10, SZ_H, 32'hAAAA1234, 0, 0, 0);
        op(0, "ldw10c", 0, 14'h10, SZ_W, 0, 32'h80AD1234, 0, 0);

`ifdef DMEM_TARGET_ERR_EN
        op(0, "e_ldh11", 0, 14'h11, SZ_H, 0, 0, 1, 0);
        op(0, "e_ldw12", 0, 14'h12, SZ_W, 0, 0, 1, 0);
        op(0, "e_stw12", 1, 14'h12, SZ_W, 32'h11223344, 0, 1, 0);
        op(0, "e_ldw10", 0, 14'h10, SZ_W, 0, 32'h80AD1234, 0, 0);
        op(0, "e_sz011", 0, 14'h10, 3'b011, 0, 0, 1, 0);
        op(0, "e_stbu", 1, 14'h13, SZ_BU, 32'h55, 0, 1, 0);
        op(0, "e_ldw10b", 0, 14'h10, SZ_W, 0, 32'h80AD1234, 0, 0);
        op(0, "e_sz110", 0, 14'h11, 3'b110, 0, 0, 1, 0);
`else
        op(0, "n_ldh11", 0, 14'h11, SZ_H, 0, 32'h00001234, 0, 0);
        op(0, "n_ldw12", 0, 14'h12, SZ_W, 0, 32'h80AD1234, 0, 0);
        op(0, "n_stw12", 1, 14'h12, SZ_W, 32'h11223344, 0, 0, 0);
        op(0, "n_ldw10", 0, 14'h10, SZ_W, 0, 32'h11223344, 0, 0);
        op(0, "n_sz011", 0, 14'h10, 3'b011, 0, 32'h11223344, 0, 0);
        op(0, "n_stbu", 1, 14'h13, SZ_BU, 32'h55, 0, 0, 0);
        op(0, "n_ldw10b", 0, 14'h10, SZ_W, 0, 32'h55223344, 0, 0);
        op(0, "n_sz110", 0, 14'h11, 3'b110, 0, 32'h55223344, 0, 0);
`endif

        op(0, "stw30", 1, 14'h30, SZ_W, 32'h0F0F1234, 0, 0, 0);
        op(0, "hold30", 0, 14'h30, SZ_W, 0, 32'h0F0F1234, 0, 5);

        // Reset one cycle after accepting a store: store must be dropped.
        op(0, "stw20", 1, 14'h20, SZ_W, 32'hCAFEF00D, 0, 0, 0);
        op(0, "ldw20", 0, 14'h20, SZ_W, 0, 32'hCAFEF00D, 0, 0);
        @(negedge clk);
        req_we[0]    = 1'b1;
        req_addr[0]  = 14'h20;
        req_size[0]  = SZ_W;
        req_wdata[0] = 32'h12345678;
        req_valid[0] = 1'b1;
        chk("abort_reqrdy", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst_n[0] = 1'b0;
        #1;
        chk("abort_reqrdy_lo", 32'(req_ready[0]), 32'd0);
        chk("abort_valid", 32'(rsp_valid[0]), 32'd0);
        chk("abort_rdata", rsp_rdata[0], 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_novalid", 32'(rsp_valid[0]), 32'd0);
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        op(0, "abort_ld20", 0, 14'h20, SZ_W, 0, 32'hCAFEF00D, 0, 0);

        op(0, "stw0000", 1, 14'h0000, SZ_W, 32'h00000000, 0, 0, 0);
        op(0, "stw3ffc", 1, 14'h3FFC, SZ_W, 32'h00000001, 0, 0, 0);
        op(0, "ldw0000", 0, 14'h0000, SZ_W, 0, 32'h00000000, 0, 0);
        op(0, "ldw3ffc", 0, 14'h3FFC, SZ_W, 0, 32'h00000001, 0, 0);

        op(1, "z_stw40", 1, 14'h40, SZ_W, 32'hA1B2C3D4, 0, 0, 0);
        op(1, "z_ldhu42", 0, 14'h42, SZ_HU, 0, 32'h0000A1B2, 0, 0);
        op(1, "z_ldb41", 0, 14'h41, SZ_B, 0, 32'hFFFFFFC3, 0, 0);
        op(1, "z_stb40", 1, 14'h40, SZ_B, 32'hFFFFFF7F, 0, 0, 0);
        op(1, "z_ldb40", 0, 14'h40, SZ_B, 0, 32'h0000007F, 0, 0);
        op(1, "z_ldh40", 0, 14'h40, SZ_H, 0, 32'hFFFFC37F, 0, 0);
        op(1, "z_ldw40", 0, 14'h40, SZ_W, 0, 32'hA1B2C37F, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
